mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter PRIO_FIXED, default 0; 0 = round-robin, 1 = port 0 always wins ties.
REQ-002 SHALL have port clk, input, 1 bit, rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have, for each N in {0,1}, port reqN, input, 1 bit, request level held high until doneN is seen (port 0 = CPU, port 1 = debug/loader).
REQ-005 SHALL have, for each N, port writeN, input, 1 bit, 1 = store, 0 = load.
REQ-006 SHALL have, for each N, port datafetchN, input, 1 bit, data-load (not instruction fetch) flag.
REQ-007 SHALL have, for each N, port nbytesN, input, 3 bits, byte count 1, 2 or 4.
REQ-008 SHALL have, for each N, port addrN, input, 32 bits, target address.
REQ-009 SHALL have, for each N, port wdataN, input, 32 bits, store data.
REQ-010 SHALL have, for each N, port doneN, output, 1 bit, completion flag for port N.
REQ-011 SHALL have, for each N, port rdataN, output, 32 bits, last load result for port N.
REQ-012 SHALL have mem_start, mem_write and mem_datafetch, outputs, 1 bit each, mirroring the latched request to the shared memory controller.
REQ-013 SHALL have mem_nbytes, output, 3 bits, and mem_addr and mem_wdata, outputs, 32 bits each, mirroring the latched request to the shared memory controller.
REQ-014 SHALL have mem_done, input, 1 bit, and mem_rdata, input, 32 bits, from the memory controller.
REQ-015 SHALL have grant, output, 2 bits, one-hot owner (00 = none).
REQ-016 SHALL have busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, BUSY and DONE.
REQ-018 In IDLE, with any reqN sampled high, the block SHALL pick a winner, latch that port's write/datafetch/nbytes/addr/wdata into the mem_* registers, set grant, set mem_start=1 and go to BUSY on the same edge; mem_start is visible one cycle after req is sampled.
REQ-019 Tie-break when PRIO_FIXED=0 SHALL grant the port not served last; the last-served pointer resets to port 1, so port 0 wins the first tie.
REQ-020 Tie-break when PRIO_FIXED=1 SHALL always grant port 0.
REQ-021 In BUSY, mem_start SHALL stay 1 and the mem_* fields SHALL stay constant regardless of upstream field changes.
REQ-022 In BUSY, on mem_done sampled 1, the block SHALL set mem_start<=0 and doneN<=1 for the granted port only, and go to DONE.
REQ-023 On that mem_done edge, if the transaction is a load, rdataN<=mem_rdata; on a store, rdataN is unchanged.
REQ-024 In DONE, doneN SHALL stay high until reqN is sampled 0 AND mem_done is sampled 0.
REQ-025 On leaving DONE: doneN<=0, grant<=00, last-served<=N, state<=IDLE.
REQ-026 A new grant SHALL be issued no earlier than the cycle after returning to IDLE, giving at least one idle cycle between transactions.
REQ-027 If reqN drops while BUSY, the transaction SHALL not be aborted; it completes and doneN is high for exactly one cycle (DONE exits immediately once mem_done is low).
REQ-028 The non-granted port's doneN SHALL stay 0 throughout and its request SHALL remain pending.
REQ-029 A port whose req stays high after its done handshake SHALL be re-granted only per the tie-break rules, so under PRIO_FIXED=0 two continuously requesting ports alternate.
REQ-030 mem_done high while in IDLE SHALL be ignored.

Reset
REQ-031 On rst_n=0 at a clock edge, the block SHALL set state=IDLE, mem_start=0, mem_write=0, mem_datafetch=0, mem_nbytes=0, mem_addr=0, mem_wdata=0.
REQ-032 On rst_n=0 at a clock edge, the block SHALL also set done0=done1=0, rdata0=rdata1=0, grant=00, busy=0 and last-served=port 1.
REQ-033 Reset asserted mid-transaction SHALL drop mem_start on that edge, with no doneN issued afterwards for the aborted transaction.

Verification
REQ-034 Bench SHALL cover: req0 load addr=0x100 nbytes=4, mem_done after 5 cycles with mem_rdata=0xDEADBEEF -> mem_start high one cycle after req0, rdata0=0xDEADBEEF, done0 held until req0 drops, grant=01 throughout.
REQ-035 Bench SHALL cover: req0 and req1 raised together and held, PRIO_FIXED=0 -> grant sequence 01,10,01,10 with an idle cycle between each.
REQ-036 Bench SHALL cover: same stimulus with PRIO_FIXED=1 -> port 0 granted every time and port 1 never served.
REQ-037 Bench SHALL cover: req1 store wdata=0x12345678 with rdata1=0xAAAA0000 beforehand -> mem_write=1, mem_wdata=0x12345678, rdata1 still 0xAAAA0000 after done1.
REQ-038 Bench SHALL cover: req0 dropped during BUSY -> done0 high exactly one cycle after mem_done, then IDLE.
REQ-039 Bench SHALL cover: rst_n low two cycles into BUSY -> next edge gives mem_start=0, grant=00, busy=0, and no done0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares one memory controller between the CPU (port 0)
// and the debug/loader (port 1). It latches the winning request and holds it steady until done.
module mem_arbiter #(
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        write0,
  input  logic        datafetch0,
  input  logic [2:0]  nbytes0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        done0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        write1,
  input  logic        datafetch1,
  input  logic [2:0]  nbytes1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        done1,
  output logic [31:0] rdata1,
  output logic        mem_start,
  output logic        mem_write,
  output logic        mem_datafetch,
  output logic [2:0]  mem_nbytes,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int unsigned DW  = 32;
  localparam int unsigned NBW = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            start_q, start_d;
  logic            write_q, write_d;
  logic            df_q, df_d;
  logic [NBW-1:0]  nb_q, nb_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      done_q, done_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;

  logic            any_req_c;
  logic            own_req_c;
  logic            pick1_c;

  assign any_req_c = req0 | req1;
  assign own_req_c = grant_q[1] ? req1 : req0;

  // Winner selection: fixed priority to port 0, or the port not served last.
  always_comb begin
    pick1_c = 1'b0;
    if (req0 && req1) begin
      pick1_c = (PRIO_FIXED != 32'd0) ? 1'b0 : ~last_q;
    end else begin
      pick1_c = req1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      write_q  <= 1'b0;
      df_q     <= 1'b0;
      nb_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      grant_q  <= 2'b00;
      done_q   <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
      last_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      write_q  <= write_d;
      df_q     <= df_d;
      nb_q     <= nb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req_c) state_d = S_BUSY;
      S_BUSY:  if (mem_done) state_d = S_DONE;
      S_DONE:  if (!own_req_c && !mem_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; the owner's done is held until it releases req.
  always_comb begin
    start_d  = start_q;
    write_d  = write_q;
    df_d     = df_q;
    nb_d     = nb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    grant_d  = grant_q;
    done_d   = done_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    last_d   = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          start_d = 1'b1;
          grant_d = pick1_c ? 2'b10 : 2'b01;
          write_d = pick1_c ? write1 : write0;
          df_d    = pick1_c ? datafetch1 : datafetch0;
          nb_d    = pick1_c ? nbytes1 : nbytes0;
          addr_d  = pick1_c ? addr1 : addr0;
          wdata_d = pick1_c ? wdata1 : wdata0;
        end
      end
      S_BUSY: begin
        if (mem_done) begin
          start_d = 1'b0;
          done_d  = grant_q;
          if (!write_q) begin
            if (grant_q[1]) rdata1_d = mem_rdata;
            else            rdata0_d = mem_rdata;
          end
        end
      end
      S_DONE: begin
        if (!own_req_c && !mem_done) begin
          done_d  = 2'b00;
          grant_d = 2'b00;
          last_d  = grant_q[1];
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign mem_start     = start_q;
  assign mem_write     = write_q;
  assign mem_datafetch = df_q;
  assign mem_nbytes    = nb_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign done0         = done_q[0];
  assign done1         = done_q[1];
  assign rdata0        = rdata0_q;
  assign rdata1        = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is round-robin, instance 1 is fixed-priority.
// A transaction-level model is stepped each clock and compared every cycle.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  logic        req_i [2][2];
  logic        wr_i  [2][2];
  logic        df_i  [2][2];
  logic [2:0]  nb_i  [2][2];
  logic [31:0] addr_i[2][2];
  logic [31:0] wd_i  [2][2];
  logic        mdone [2];
  logic [31:0] mrdata[2];

  logic        done_o [2][2];
  logic [31:0] rdata_o[2][2];
  logic        ms_o  [2];
  logic        mw_o  [2];
  logic        mdf_o [2];
  logic [2:0]  mnb_o [2];
  logic [31:0] ma_o  [2];
  logic [31:0] mwd_o [2];
  logic [1:0]  gr_o  [2];
  logic        busy_o[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.PRIO_FIXED(g)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0         (req_i[g][0]),
      .write0       (wr_i[g][0]),
      .datafetch0   (df_i[g][0]),
      .nbytes0      (nb_i[g][0]),
      .addr0        (addr_i[g][0]),
      .wdata0       (wd_i[g][0]),
      .done0        (done_o[g][0]),
      .rdata0       (rdata_o[g][0]),
      .req1         (req_i[g][1]),
      .write1       (wr_i[g][1]),
      .datafetch1   (df_i[g][1]),
      .nbytes1      (nb_i[g][1]),
      .addr1        (addr_i[g][1]),
      .wdata1       (wd_i[g][1]),
      .done1        (done_o[g][1]),
      .rdata1       (rdata_o[g][1]),
      .mem_start    (ms_o[g]),
      .mem_write    (mw_o[g]),
      .mem_datafetch(mdf_o[g]),
      .mem_nbytes   (mnb_o[g]),
      .mem_addr     (ma_o[g]),
      .mem_wdata    (mwd_o[g]),
      .mem_done     (mdone[g]),
      .mem_rdata    (mrdata[g]),
      .grant        (gr_o[g]),
      .busy         (busy_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner (-1 none), phase 0 idle / 1 waiting on memory / 2 handshake.
  int          own  [2];
  int          ph   [2];
  int          last [2];
  logic        e_start[2], e_wr[2], e_df[2], e_busy[2];
  logic [2:0]  e_nb[2];
  logic [31:0] e_addr[2], e_wd[2];
  logic [1:0]  e_gr[2];
  logic        e_done [2][2];
  logic [31:0] e_rdata[2][2];

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[inst%0d] t=%0t: got %h expected %h", nm, inst, $time, act, exp);
  endtask

  task automatic model_reset(input int i);
    own[i] = -1; ph[i] = 0; last[i] = 1;
    e_start[i] = 0; e_wr[i] = 0; e_df[i] = 0; e_nb[i] = '0;
    e_addr[i] = '0; e_wd[i] = '0; e_gr[i] = 2'b00; e_busy[i] = 0;
    for (int p = 0; p < 2; p++) begin
      e_done[i][p] = 0;
      e_rdata[i][p] = '0;
    end
  endtask

  task automatic model_step();
    int w;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        model_reset(i);
      end else if (ph[i] == 0) begin
        if (req_i[i][0] || req_i[i][1]) begin
          if (req_i[i][0] && req_i[i][1]) w = (i == 1) ? 0 : 1 - last[i];
          else w = req_i[i][0] ? 0 : 1;
          own[i] = w; ph[i] = 1;
          e_start[i] = 1; e_gr[i] = (w == 1) ? 2'b10 : 2'b01;
          e_wr[i] = wr_i[i][w]; e_df[i] = df_i[i][w]; e_nb[i] = nb_i[i][w];
          e_addr[i] = addr_i[i][w]; e_wd[i] = wd_i[i][w];
        end
      end else if (ph[i] == 1) begin
        if (mdone[i]) begin
          e_start[i] = 0; ph[i] = 2;
          e_done[i][own[i]] = 1;
          if (!e_wr[i]) e_rdata[i][own[i]] = mrdata[i];
        end
      end else begin
        if (!req_i[i][own[i]] && !mdone[i]) begin
          e_done[i][own[i]] = 0; e_gr[i] = 2'b00;
          last[i] = own[i]; own[i] = -1; ph[i] = 0;
        end
      end
      e_busy[i] = (ph[i] != 0);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk("mem_start", i, 32'(ms_o[i]), 32'(e_start[i]));
      chk("mem_write", i, 32'(mw_o[i]), 32'(e_wr[i]));
      chk("mem_datafetch", i, 32'(mdf_o[i]), 32'(e_df[i]));
      chk("mem_nbytes", i, 32'(mnb_o[i]), 32'(e_nb[i]));
      chk("mem_addr", i, ma_o[i], e_addr[i]);
      chk("mem_wdata", i, mwd_o[i], e_wd[i]);
      chk("grant", i, 32'(gr_o[i]), 32'(e_gr[i]));
      chk("busy", i, 32'(busy_o[i]), 32'(e_busy[i]));
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("done%0d", p), i, 32'(done_o[i][p]), 32'(e_done[i][p]));
        chk($sformatf("rdata%0d", p), i, rdata_o[i][p], e_rdata[i][p]);
      end
    end
  endtask

  // Compare at the falling edge, step the model on the rising edge, drive 1 time unit later.
  task automatic tick();
    @(negedge clk);
    if (cmp_en) compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_req(input int i, input int p, input logic w, input logic df,
                         input logic [2:0] nb, input logic [31:0] a, input logic [31:0] wd);
    req_i[i][p] = 1'b1; wr_i[i][p] = w; df_i[i][p] = df;
    nb_i[i][p] = nb; addr_i[i][p] = a; wd_i[i][p] = wd;
  endtask

  task automatic wait_start(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (ms_o[i]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("start_seen", i, 32'(ok), 32'd1);
  endtask

  // Both ports request; each owner drops req for one cycle after done, then re-requests.
  task automatic run_alt(input int i);
    bit ok;
    int p;
    logic [1:0] exp_g;
    set_req(i, 0, 1'b0, 1'b1, 3'd4, 32'h0000_1000, 32'h0);
    set_req(i, 1, 1'b1, 1'b0, 3'd2, 32'h0000_2000, 32'h0BAD_F00D);
    for (int k = 0; k < 4; k++) begin
      wait_start(i, ok);
      if (!ok) return;
      exp_g = (i == 1) ? 2'b01 : (((k % 2) == 0) ? 2'b01 : 2'b10);
      chk($sformatf("alt_grant%0d", k), i, 32'(gr_o[i]), 32'(exp_g));
      p = gr_o[i][1] ? 1 : 0;
      tick();
      tick();
      mdone[i] = 1'b1; mrdata[i] = 32'h1000 + 32'(k);
      tick();
      mdone[i] = 1'b0;
      chk("alt_done", i, 32'(done_o[i][p]), 32'd1);
      req_i[i][p] = 1'b0;
      if (k == 3) req_i[i][1-p] = 1'b0;
      tick();
      chk("alt_idle_gap", i, 32'(busy_o[i]), 32'd0);
      req_i[i][p] = (k < 3);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mdone[i] = 1'b0; mrdata[i] = '0;
      for (int p = 0; p < 2; p++) begin
        req_i[i][p] = 1'b0; wr_i[i][p] = 1'b0; df_i[i][p] = 1'b0;
        nb_i[i][p] = '0; addr_i[i][p] = '0; wd_i[i][p] = '0;
      end
      model_reset(i);
    end
    tick();
    cmp_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_start", 0, 32'(ms_o[0]), 32'd0);
    chk("rst_grant", 0, 32'(gr_o[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("rst_rdata0", 0, rdata_o[0][0], 32'd0);

    // Single load on port 0; memory answers on the fifth cycle of BUSY.
    set_req(0, 0, 1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'h0);
    tick();
    chk("s1_start", 0, 32'(ms_o[0]), 32'd1);
    chk("s1_addr", 0, ma_o[0], 32'h0000_0100);
    chk("s1_nbytes", 0, 32'(mnb_o[0]), 32'd4);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("s1_grant_busy", 0, 32'(gr_o[0]), 32'd1);
    end
    mdone[0] = 1'b1; mrdata[0] = 32'hDEAD_BEEF;
    tick();
    mdone[0] = 1'b0; mrdata[0] = 32'h0;
    chk("s1_rdata0", 0, rdata_o[0][0], 32'hDEAD_BEEF);
    chk("s1_done0", 0, 32'(done_o[0][0]), 32'd1);
    chk("s1_start_drop", 0, 32'(ms_o[0]), 32'd0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("s1_done_hold", 0, 32'(done_o[0][0]), 32'd1);
      chk("s1_grant_hold", 0, 32'(gr_o[0]), 32'd1);
    end
    req_i[0][0] = 1'b0;
    tick();
    chk("s1_done_clr", 0, 32'(done_o[0][0]), 32'd0);
    chk("s1_grant_clr", 0, 32'(gr_o[0]), 32'd0);
    tick();

    // Port 1 load to preset rdata1, then a store that must leave it alone.
    set_req(0, 1, 1'b0, 1'b1, 3'd4, 32'h0000_0200, 32'h0);
    tick();
    tick();
    mdone[0] = 1'b1; mrdata[0] = 32'hAAAA_0000;
    tick();
    mdone[0] = 1'b0; req_i[0][1] = 1'b0;
    chk("s4_preload", 0, rdata_o[0][1], 32'hAAAA_0000);
    tick();
    tick();
    set_req(0, 1, 1'b1, 1'b0, 3'd4, 32'h0000_0204, 32'h1234_5678);
    tick();
    chk("s4_write", 0, 32'(mw_o[0]), 32'd1);
    chk("s4_wdata", 0, mwd_o[0], 32'h1234_5678);
    chk("s4_grant", 0, 32'(gr_o[0]), 32'd2);
    wd_i[0][1] = 32'hFFFF_FFFF; addr_i[0][1] = 32'h0;
    tick();
    chk("s4_wdata_held", 0, mwd_o[0], 32'h1234_5678);
    mdone[0] = 1'b1; mrdata[0] = 32'h5555_5555;
    tick();
    mdone[0] = 1'b0; req_i[0][1] = 1'b0;
    chk("s4_done1", 0, 32'(done_o[0][1]), 32'd1);
    chk("s4_rdata1_kept", 0, rdata_o[0][1], 32'hAAAA_0000);
    tick();
    tick();

    // Port 0 drops req while BUSY: done0 pulses for exactly one cycle.
    set_req(0, 0, 1'b0, 1'b0, 3'd1, 32'h0000_0300, 32'h0);
    tick();
    req_i[0][0] = 1'b0;
    tick();
    tick();
    mdone[0] = 1'b1; mrdata[0] = 32'hCAFE_F00D;
    tick();
    mdone[0] = 1'b0;
    chk("s5_done_pulse", 0, 32'(done_o[0][0]), 32'd1);
    tick();
    chk("s5_done_gone", 0, 32'(done_o[0][0]), 32'd0);
    chk("s5_idle", 0, 32'(busy_o[0]), 32'd0);
    tick();

    // Reset two cycles into BUSY; a stray mem_done afterwards must not produce done0.
    set_req(0, 0, 1'b0, 1'b1, 3'd4, 32'h0000_0400, 32'h0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("s6_start", 0, 32'(ms_o[0]), 32'd0);
    chk("s6_grant", 0, 32'(gr_o[0]), 32'd0);
    chk("s6_busy", 0, 32'(busy_o[0]), 32'd0);
    rst_n = 1'b1; req_i[0][0] = 1'b0; mdone[0] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      mdone[0] = 1'b0;
      chk("s6_no_done", 0, 32'(done_o[0][0]), 32'd0);
    end

    // Continuous contention: alternation on instance 0, port 0 only on instance 1.
    run_alt(0);
    run_alt(1);
    tick();

    // Random traffic, field churn, stray mem_done and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (!req_i[i][p]) begin
            if ($urandom_range(3) == 0) begin
              set_req(i, p, 1'($urandom_range(1)), 1'($urandom_range(1)),
                      3'(1 << $urandom_range(2)), $urandom, $urandom);
            end
          end else if (e_done[i][p]) begin
            if ($urandom_range(1) == 0) req_i[i][p] = 1'b0;
          end else if ($urandom_range(31) == 0) begin
            req_i[i][p] = 1'b0;
          end
          if ($urandom_range(3) == 0) begin
            addr_i[i][p] = $urandom; wd_i[i][p] = $urandom;
            wr_i[i][p] = 1'($urandom_range(1)); nb_i[i][p] = 3'(1 << $urandom_range(2));
          end
        end
        mdone[i] = ($urandom_range(3) == 0);
        mrdata[i] = $urandom;
      end
      rst_n = ($urandom_range(499) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
